// File: rtl/seq_signed_divider_pkg.sv
// rtl/seq_signed_divider_pkg.sv - shared widths and FSM state type for the iterative signed divider
package seq_signed_divider_pkg;

    localparam int BYTE_BITS    = 8;
    localparam int DEF_NUM_BITS = 2 * BYTE_BITS - 1;
    localparam int DEF_DEN_BITS = BYTE_BITS;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_restore_step #(
    parameter int DEN_BITS = 8
) (
    input  logic [DEN_BITS:0]   i_part,
    input  logic                i_bit,
    input  logic [DEN_BITS-1:0] i_dsr,
    output logic [DEN_BITS:0]   o_part,
    output logic                o_qbit
);

    logic [DEN_BITS:0] w_shifted;
    logic [DEN_BITS:0] w_diff;
    logic              w_ge;

    // A set top bit of the incoming remainder means the shifted value already exceeds any divisor.
    assign w_shifted = {i_part[DEN_BITS-1:0], i_bit};
    assign w_ge      = i_part[DEN_BITS] | (w_shifted >= {1'b0, i_dsr});
    assign w_diff    = w_shifted - {1'b0, i_dsr};
    assign o_qbit    = w_ge;
    assign o_part    = w_ge ? w_diff : w_shifted;

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative signed divider, one quotient bit per cycle, valid/ready in and out
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int DEN_BITS = DEF_DEN_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [DEN_BITS-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] quotient,
    output logic [DEN_BITS-1:0] remainder,
    output logic                err
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [NUM_BITS-1:0] MAX_POS = {1'b0, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

    div_state_t          r_state;
    div_state_t          w_state_nxt;

    logic [NUM_BITS-1:0] r_dvd_mag;
    logic [DEN_BITS-1:0] r_dsr_mag;
    logic                r_sign;
    logic                r_rsign;
    logic [DEN_BITS:0]   r_part;
    logic [NUM_BITS-2:0] r_qmag;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_quot;
    logic [DEN_BITS-1:0] r_rem;
    logic                r_err;

    logic                w_dvd_neg;
    logic                w_dsr_neg;
    logic                w_dsr_zero;
    logic [NUM_BITS-1:0] w_dvd_mag;
    logic [DEN_BITS-1:0] w_dsr_mag;
    logic [DEN_BITS:0]   w_part_nxt;
    logic                w_qbit;
    logic [NUM_BITS-1:0] w_qmag_fin;
    logic [DEN_BITS-1:0] w_rem_mag;
    logic                w_ovf;
    logic [NUM_BITS-1:0] w_quot_fix;
    logic [DEN_BITS-1:0] w_rem_fix;

    assign w_dvd_neg  = dividend[NUM_BITS-1];
    assign w_dsr_neg  = divisor[DEN_BITS-1];
    assign w_dsr_zero = (divisor == '0);
    assign w_dvd_mag  = w_dvd_neg ? (~dividend + NUM_BITS'(1)) : dividend;
    assign w_dsr_mag  = w_dsr_neg ? (~divisor + DEN_BITS'(1)) : divisor;

    div_restore_step #(
        .DEN_BITS (DEN_BITS)
    ) u_step (
        .i_part (r_part),
        .i_bit  (r_dvd_mag[NUM_BITS-1]),
        .i_dsr  (r_dsr_mag),
        .o_part (w_part_nxt),
        .o_qbit (w_qbit)
    );

    // The last quotient bit is never registered in r_qmag; it joins here on the final step.
    assign w_qmag_fin = {r_qmag, w_qbit};
    assign w_rem_mag  = w_part_nxt[DEN_BITS-1:0];
    assign w_ovf      = !r_sign && (w_qmag_fin == MIN_NEG);
    assign w_quot_fix = w_ovf ? MAX_POS : (r_sign ? (~w_qmag_fin + NUM_BITS'(1)) : w_qmag_fin);
    assign w_rem_fix  = r_rsign ? (~w_rem_mag + DEN_BITS'(1)) : w_rem_mag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_dsr_zero ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dvd_mag <= '0;
            r_dsr_mag <= '0;
            r_sign    <= 1'b0;
            r_rsign   <= 1'b0;
            r_part    <= '0;
            r_qmag    <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (in_valid) begin
                        r_dvd_mag <= w_dvd_mag;
                        r_dsr_mag <= w_dsr_mag;
                        r_sign    <= w_dvd_neg ^ w_dsr_neg;
                        r_rsign   <= w_dvd_neg;
                        r_part    <= '0;
                        r_qmag    <= '0;
                        r_cnt     <= CNT_W'(NUM_BITS - 1);
                        if (w_dsr_zero) begin
                            r_quot <= w_dvd_neg ? MIN_NEG : MAX_POS;
                            r_rem  <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                DIV_CALC: begin
                    r_part    <= w_part_nxt;
                    r_qmag    <= {r_qmag[NUM_BITS-3:0], w_qbit};
                    r_dvd_mag <= {r_dvd_mag[NUM_BITS-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                        r_err  <= w_ovf;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign err       = r_err;

endmodule
